// File: rtl/bj_pkg.sv
// Shared blackjack definitions: deck geometry, card field types and the
// rank-to-points rule used by the dealer and the hand scorer.
package bj_pkg;

   localparam int DECK_SIZE = 52;
   localparam int RANKS     = 13;
   localparam int SUITS     = 4;

   typedef logic [5:0] card_idx_t;
   typedef logic [3:0] rank_t;
   typedef logic [1:0] suit_t;
   typedef logic [3:0] points_t;

   typedef enum logic {
      IDLE  = 1'b0,
      PROBE = 1'b1
   } dealer_state_t;

   // Ace counts high here; the hand scorer demotes it to 1 when needed.
   function automatic points_t points_from_rank(input rank_t rank);
      points_t pts;
      if (rank == 4'd1) begin
         pts = 4'd11;
      end else if (rank >= 4'd10) begin
         pts = 4'd10;
      end else begin
         pts = rank;
      end
      return pts;
   endfunction

endpackage

// File: rtl/card_decode.sv
// Combinational card decoder: index 0..51 to rank 1..13, suit 0..3 and
// blackjack points.
module card_decode
   import bj_pkg::*;
(
   input  logic [5:0] idx_i,
   output logic [3:0] rank_o,
   output logic [1:0] suit_o,
   output logic [3:0] points_o
);

   card_idx_t base_s;
   card_idx_t offset_s;

   // Suit by range compare; the offset within the suit is always below 13.
   always_comb begin
      base_s = 6'd0;
      suit_o = 2'd0;
      if (idx_i >= 6'd39) begin
         base_s = 6'd39;
         suit_o = 2'd3;
      end else if (idx_i >= 6'd26) begin
         base_s = 6'd26;
         suit_o = 2'd2;
      end else if (idx_i >= 6'd13) begin
         base_s = 6'd13;
         suit_o = 2'd1;
      end else begin
         base_s = 6'd0;
         suit_o = 2'd0;
      end
      offset_s = idx_i - base_s;
      rank_o   = offset_s[3:0] + 4'd1;
      points_o = points_from_rank(rank_o);
   end

   logic [1:0] unused_offset_s;
   assign unused_offset_s = offset_s[5:4];

endmodule

// File: rtl/card_dealer.sv
// Deals unique cards from one 52-card deck: the random start slot is
// linearly probed past already-dealt cards until a free one is found.
module card_dealer
   import bj_pkg::*;
#(
   parameter int RND_W = 8
) (
   input  logic             CLOCK_50,
   input  logic             reset_n,
   input  logic [RND_W-1:0] rnd,
   input  logic             draw_req,
   input  logic             shuffle_req,
   output logic             card_valid,
   output logic [5:0]       card_idx,
   output logic [3:0]       card_rank,
   output logic [1:0]       card_suit,
   output logic [3:0]       card_points,
   output logic [5:0]       cards_left,
   output logic             deck_empty,
   output logic             busy,
   output logic             draw_err
);

   dealer_state_t state_q;
   logic [51:0]   used_q;
   card_idx_t     ptr_q;
   logic          hit_q;

   logic [7:0]    rnd_ext_d;
   card_idx_t     start_ptr_d;
   card_idx_t     next_ptr_d;
   rank_t         dec_rank_d;
   suit_t         dec_suit_d;
   points_t       dec_points_d;

   // Reduce a byte mod 52 with at most one subtraction of a multiple of 52.
   function automatic card_idx_t mod52(input logic [7:0] v);
      logic [7:0] r;
      if (v >= 8'd208) begin
         r = v - 8'd208;
      end else if (v >= 8'd156) begin
         r = v - 8'd156;
      end else if (v >= 8'd104) begin
         r = v - 8'd104;
      end else if (v >= 8'd52) begin
         r = v - 8'd52;
      end else begin
         r = v;
      end
      return card_idx_t'(r);
   endfunction

   assign rnd_ext_d   = 8'(rnd);
   assign start_ptr_d = mod52(rnd_ext_d);
   assign next_ptr_d  = (ptr_q == 6'd51) ? 6'd0 : ptr_q + 6'd1;

   card_decode u_decode (
      .idx_i    (ptr_q),
      .rank_o   (dec_rank_d),
      .suit_o   (dec_suit_d),
      .points_o (dec_points_d)
   );

   // hit_q adds one delivery cycle so valid, card fields and counters move together.
   always_ff @(posedge CLOCK_50 or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         used_q      <= 52'd0;
         ptr_q       <= 6'd0;
         hit_q       <= 1'b0;
         card_valid  <= 1'b0;
         card_idx    <= 6'd0;
         card_rank   <= 4'd0;
         card_suit   <= 2'd0;
         card_points <= 4'd0;
         cards_left  <= 6'd52;
         deck_empty  <= 1'b0;
         busy        <= 1'b0;
         draw_err    <= 1'b0;
      end else begin
         card_valid <= 1'b0;
         draw_err   <= 1'b0;
         case (state_q)
            IDLE: begin
               busy <= 1'b0;
               if (!busy) begin
                  if (shuffle_req) begin
                     used_q     <= 52'd0;
                     cards_left <= 6'd52;
                     deck_empty <= 1'b0;
                  end else if (draw_req) begin
                     if (cards_left == 6'd0) begin
                        draw_err <= 1'b1;
                     end else begin
                        ptr_q   <= start_ptr_d;
                        hit_q   <= 1'b0;
                        busy    <= 1'b1;
                        state_q <= PROBE;
                     end
                  end
               end
            end
            PROBE: begin
               if (hit_q) begin
                  used_q[ptr_q] <= 1'b1;
                  cards_left    <= cards_left - 6'd1;
                  deck_empty    <= (cards_left == 6'd1);
                  card_valid    <= 1'b1;
                  card_idx      <= ptr_q;
                  card_rank     <= dec_rank_d;
                  card_suit     <= dec_suit_d;
                  card_points   <= dec_points_d;
                  hit_q         <= 1'b0;
                  state_q       <= IDLE;
               end else if (used_q[ptr_q]) begin
                  ptr_q <= next_ptr_d;
               end else begin
                  hit_q <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               busy    <= 1'b0;
               hit_q   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer; expected cards go into a scoreboard queue
// and a negedge monitor pops and compares them when card_valid appears.
module tb_card_dealer;

   logic       CLOCK_50 = 1'b0;
   logic       reset_n  = 1'b0;
   logic [7:0] rnd      = 8'd0;
   logic       draw_req = 1'b0;
   logic       shuffle_req = 1'b0;
   logic       card_valid;
   logic [5:0] card_idx;
   logic [3:0] card_rank;
   logic [1:0] card_suit;
   logic [3:0] card_points;
   logic [5:0] cards_left;
   logic       deck_empty;
   logic       busy;
   logic       draw_err;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      int idx;
      int rank;
      int suit;
      int pts;
      int left;
      int cyc;
   } exp_t;

   exp_t exp_q[$];
   int   err_q[$];

   card_dealer #(.RND_W(8)) dut (
      .CLOCK_50    (CLOCK_50),
      .reset_n     (reset_n),
      .rnd         (rnd),
      .draw_req    (draw_req),
      .shuffle_req (shuffle_req),
      .card_valid  (card_valid),
      .card_idx    (card_idx),
      .card_rank   (card_rank),
      .card_suit   (card_suit),
      .card_points (card_points),
      .cards_left  (cards_left),
      .deck_empty  (deck_empty),
      .busy        (busy),
      .draw_err    (draw_err)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   always @(posedge CLOCK_50) cyc <= cyc + 1;

   function automatic void chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic int ref_pts(input int rk);
      if (rk == 1) return 11;
      if (rk > 10) return 10;
      return rk;
   endfunction

   // Monitor: pop the scoreboard whenever the DUT presents a card or an error.
   always @(negedge CLOCK_50) begin
      if (reset_n) begin
         if (card_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_card_valid", int'(card_valid), 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("card_idx",    int'(card_idx),    e.idx);
               chk("card_rank",   int'(card_rank),   e.rank);
               chk("card_suit",   int'(card_suit),   e.suit);
               chk("card_points", int'(card_points), e.pts);
               chk("cards_left",  int'(cards_left),  e.left);
               chk("deck_empty",  int'(deck_empty),  (e.left == 0) ? 1 : 0);
               chk("valid_cycle", cyc,               e.cyc);
               chk("busy_at_valid", int'(busy),      1);
            end
         end
         if (draw_err) begin
            if (err_q.size() == 0) begin
               chk("unexpected_draw_err", int'(draw_err), 0);
            end else begin
               chk("draw_err_cycle", cyc, err_q.pop_front());
            end
         end
      end
   end

   task automatic wait_drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 80) begin
         @(negedge CLOCK_50);
         #1;
         n++;
      end
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic draw(input int r, input int idx, input int rk, input int st,
                       input int pts, input int left, input int lat);
      exp_t e;
      @(negedge CLOCK_50);
      rnd      = 8'(r);
      draw_req = 1'b1;
      e = '{idx, rk, st, pts, left, cyc + 1 + lat};
      exp_q.push_back(e);
      @(negedge CLOCK_50);
      draw_req = 1'b0;
      chk("busy_after_accept", int'(busy), 1);
      wait_drain();
   endtask

   task automatic shuffle();
      @(negedge CLOCK_50);
      shuffle_req = 1'b1;
      @(negedge CLOCK_50);
      shuffle_req = 1'b0;
      chk("shuffle_left",  int'(cards_left), 52);
      chk("shuffle_empty", int'(deck_empty), 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge CLOCK_50);
      chk("rst_left_in_reset", int'(cards_left), 52);
      reset_n = 1'b1;
      @(negedge CLOCK_50);
      chk("rst_left",   int'(cards_left),  52);
      chk("rst_empty",  int'(deck_empty),  0);
      chk("rst_busy",   int'(busy),        0);
      chk("rst_valid",  int'(card_valid),  0);
      chk("rst_err",    int'(draw_err),    0);
      chk("rst_idx",    int'(card_idx),    0);
      chk("rst_rank",   int'(card_rank),   0);
      chk("rst_suit",   int'(card_suit),   0);
      chk("rst_points", int'(card_points), 0);

      draw(0,   0,  1, 0, 11, 51, 2);
      draw(0,   1,  2, 0,  2, 50, 3);
      draw(255, 47, 9, 3,  9, 49, 2);
      repeat (4) @(negedge CLOCK_50);
      chk("hold_idx",    int'(card_idx),    47);
      chk("hold_points", int'(card_points), 9);

      shuffle();
      draw(51,  51, 13, 3, 10, 51, 2);
      draw(51,  0,   1, 0, 11, 50, 3);
      draw(200, 44,  6, 3,  6, 49, 2);
      draw(13,  13,  1, 1, 11, 48, 2);
      draw(36,  36, 11, 2, 10, 47, 2);
      draw(104, 1,   2, 0,  2, 46, 3);

      shuffle();
      for (int i = 0; i < 52; i++) begin
         draw(0, i, (i % 13) + 1, i / 13, ref_pts((i % 13) + 1), 51 - i, 2 + i);
      end
      @(negedge CLOCK_50);
      chk("exhaust_left",  int'(cards_left), 0);
      chk("exhaust_empty", int'(deck_empty), 1);

      @(negedge CLOCK_50);
      rnd      = 8'd9;
      draw_req = 1'b1;
      err_q.push_back(cyc + 1);
      @(negedge CLOCK_50);
      draw_req = 1'b0;
      chk("err_busy", int'(busy), 0);
      repeat (3) @(negedge CLOCK_50);
      #1;
      chk("err_seen",  err_q.size(),     0);
      chk("err_left",  int'(cards_left), 0);
      chk("err_empty", int'(deck_empty), 1);
      err_q.delete();

      @(negedge CLOCK_50);
      rnd         = 8'd5;
      shuffle_req = 1'b1;
      draw_req    = 1'b1;
      @(negedge CLOCK_50);
      shuffle_req = 1'b0;
      draw_req    = 1'b0;
      chk("shdraw_left",  int'(cards_left), 52);
      chk("shdraw_empty", int'(deck_empty), 0);
      repeat (4) @(negedge CLOCK_50);
      chk("shdraw_busy",  int'(busy),       0);
      chk("shdraw_left2", int'(cards_left), 52);

      draw(0, 0, 1, 0, 11, 51, 2);
      @(negedge CLOCK_50);
      rnd      = 8'd0;
      draw_req = 1'b1;
      @(negedge CLOCK_50);
      draw_req = 1'b0;
      chk("probe_busy", int'(busy), 1);
      #1;
      reset_n = 1'b0;
      #1;
      chk("arst_busy",  int'(busy),       0);
      chk("arst_left",  int'(cards_left), 52);
      chk("arst_idx",   int'(card_idx),   0);
      repeat (3) @(negedge CLOCK_50);
      reset_n = 1'b1;
      repeat (6) @(negedge CLOCK_50);
      chk("post_rst_left",  int'(cards_left), 52);
      chk("post_rst_busy",  int'(busy),       0);
      chk("post_rst_valid", int'(card_valid), 0);
      chk("post_rst_rank",  int'(card_rank),  0);
      chk("leftover_exp",   exp_q.size(),     0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/card_dealer.md
# card_dealer

Draws cards without replacement from a single 52-card deck. It consumes the random byte from the RNG stage and turns each draw request into a unique card index with rank, suit and blackjack point value. It sits between the RNG and the game-control FSM, and tracks which cards have already been dealt until the next shuffle.

## Interface
- `RND_W`, default 8: width of the random input. Must be ≥ 6 and ≤ 8.
- `CLOCK_50` in, 1 bit: 50 MHz system clock. Every register is rising-edge.
- `reset_n` in, 1 bit: asynchronous, active-low reset. Driven from `KEY[1]` at top level.
- `rnd` in, `RND_W` bits: current RNG value, sampled only when a draw is accepted.
- `draw_req` in, 1 bit: one-cycle request to deal one card.
- `shuffle_req` in, 1 bit: one-cycle request to return all cards to the deck.
- `card_valid` out, 1 bit: one-cycle pulse; the card outputs below are new.
- `card_idx` out, 6 bits: dealt card, 0..51.
- `card_rank` out, 4 bits: 1..13 (A=1, J=11, Q=12, K=13).
- `card_suit` out, 2 bits: 0..3.
- `card_points` out, 4 bits: A=11, 2..10 = rank, J/Q/K = 10.
- `cards_left` out, 6 bits: undealt cards, 0..52.
- `deck_empty` out, 1 bit: high when `cards_left == 0`.
- `busy` out, 1 bit: high while a draw is in progress.
- `draw_err` out, 1 bit: one-cycle pulse when a draw is requested on an empty deck.

## Operation
- State: 52-bit `used` mask, 6-bit probe pointer `ptr`, FSM with states IDLE and PROBE.
- Reset values: `used` = 0, `cards_left` = 52, `busy` = 0, `card_valid` = 0, `draw_err` = 0, `deck_empty` = 0.
- Reset values, continued: `card_idx`, `card_rank`, `card_suit` and `card_points` all 0. FSM starts in IDLE.
- IDLE, `shuffle_req` high: clear `used`, set `cards_left` = 52. Shuffle has priority over `draw_req` in the same cycle; that draw is dropped.
- IDLE, `draw_req` high, `cards_left` = 0: pulse `draw_err`. No state change.
- IDLE, `draw_req` high, `cards_left` > 0: load `ptr` = `rnd mod 52`, go to PROBE.
- `rnd mod 52` is computed combinationally by compare-subtract against 208/156/104/52. No divider.
- PROBE, `used[ptr]` = 0: set `used[ptr]`, decrement `cards_left`, and register `card_idx` = `ptr` with its decoded rank, suit and points. Pulse `card_valid` and return to IDLE.
- PROBE, `used[ptr]` = 1: `ptr` ← `ptr` + 1, wrapping 51 → 0. Stay in PROBE.
- Termination is guaranteed because `cards_left` > 0 was checked on entry.
- Decode: `suit` = `idx / 13`, `rank` = `idx − 13·suit + 1`.
- `draw_req` and `shuffle_req` are ignored while `busy`. They are not queued.
- Card outputs hold their last value until the next `card_valid`.

## Timing
- `busy` is registered: high from the cycle after an accepted draw until the cycle `card_valid` is high. Both fall together on the following edge.
- Latency, defined as accept edge to `card_valid` high: 2 cycles when the first probe hits, 2 + k when k consecutive dealt slots are skipped. Worst case is 53 cycles.
- `card_valid` and the card outputs change on the same edge.
- `cards_left` and `deck_empty` update on that same edge.
- `draw_err` is asserted the cycle after the rejected request.
- Reset asserted mid-PROBE: everything returns to reset values asynchronously, the FSM goes to IDLE, and no `card_valid` is issued.

## Structure
- Package `bj_pkg` holds the following.
  - Constants: `DECK_SIZE` = 52, `RANKS` = 13, `SUITS` = 4.
  - Typedefs: 6-bit card index, 4-bit rank, 2-bit suit, 4-bit points.
  - Function: points from rank.
- Sub-module `card_decode` (combinational): maps `idx` to `rank`, `suit` and `points`. It is reused later by the hand-score block.

## Test plan
- Reset, then idle: `cards_left` = 52, `deck_empty` = 0, `busy` = 0. All card outputs 0.
- Fresh deck, `draw_req` with `rnd` = 0: `card_valid` 2 cycles later with `idx` 0, `rank` 1, `suit` 0, `points` 11. `cards_left` = 51.
- Draw again with `rnd` = 0: `card_valid` after 3 cycles, `idx` 1, `points` 2.
- `rnd` = 255 on a fresh deck: `idx` 47, `rank` 9, `suit` 3, `points` 9.
- Wrap case: deal `idx` 51, then draw with `rnd` = 51 → `idx` 0 after 3 cycles. On a fresh deck, `idx` 51 itself decodes to `rank` 13, `points` 10.
- Exhaustion, then shuffle, then reset:
  - 52 draws give 52 distinct indices, and `deck_empty` = 1.
  - A 53rd draw gives a `draw_err` pulse and no `card_valid`.
  - `shuffle_req` together with `draw_req`: `cards_left` = 52 and no card is dealt.
  - Reset asserted during PROBE: no `card_valid`, and `cards_left` = 52.
